// File: rtl/rx_ctrl_module_pkg.sv
// Shared UART definitions: receiver state encodings, frame width default,
// bit-index width and the 9600 bps baud-generator constants at 50 MHz.
`timescale 1ns/1ps
package rx_ctrl_module_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int BIT_IDX_W     = 4;

    // Baud generator terminal counts: full bit period and mid-bit offset.
    localparam int BPS_FULL_CNT  = 5208;
    localparam int BPS_HALF_CNT  = 2604;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_ctrl_module_edge_detect.sv
// Two-flop synchronizer for the asynchronous RX line plus a one-flop delay
// used to flag high-to-low transitions of the synchronized line.
`timescale 1ns/1ps
module rx_edge_detect (
    input  logic CLK,
    input  logic RSTn,
    input  logic RX_Pin_In,
    output logic RX_Sync,
    output logic H2L_Sig
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Reset to the idle-high line level so release never looks like an edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= RX_Pin_In;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign RX_Sync = sync2_q;
    assign H2L_Sig = ~sync2_q & dly_q;

endmodule

// File: rtl/rx_ctrl_module.sv
// UART receive controller: waits for a start edge, samples each bit on the
// baud generator's mid-bit strobe and reports the byte with a done pulse.
`timescale 1ns/1ps
module rx_ctrl_module
    import rx_ctrl_module_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RX_Pin_In,
    input  logic                 RX_En_Sig,
    input  logic                 BPS_CLK,
    output logic                 Count_Sig,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Done_Sig,
    output logic                 Frame_Err,
    output rx_state_e            Dbg_State
);

    logic rx_sync;
    logic h2l;

    rx_edge_detect u_edge (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .RX_Pin_In (RX_Pin_In),
        .RX_Sync   (rx_sync),
        .H2L_Sig   (h2l)
    );

    rx_state_e              state_q, state_d;
    logic                   count_q, count_d;
    logic [DATA_BITS-1:0]   data_q,  data_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   idx_q,   idx_d;
    logic                   done_q,  done_d;
    logic                   ferr_q,  ferr_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            count_q <= 1'b0;
            data_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Done and Frame_Err are one-cycle registered outputs, so both default low.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                count_d = 1'b0;
                if (h2l && RX_En_Sig) begin
                    state_d = ST_START;
                    count_d = 1'b1;
                end
            end
            ST_START: begin
                if (!RX_En_Sig) begin
                    state_d = ST_IDLE;
                    count_d = 1'b0;
                end else if (BPS_CLK) begin
                    if (!rx_sync) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        count_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (!RX_En_Sig) begin
                    state_d = ST_IDLE;
                    count_d = 1'b0;
                end else if (BPS_CLK) begin
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + BIT_IDX_W'(1);
                    if (idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (!RX_En_Sig) begin
                    state_d = ST_IDLE;
                    count_d = 1'b0;
                end else if (BPS_CLK) begin
                    data_d  = shift_q;
                    ferr_d  = ~rx_sync;
                    done_d  = 1'b1;
                    count_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                count_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                count_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Count_Sig   = count_q;
    assign RX_Data     = data_q;
    assign RX_Done_Sig = done_q;
    assign Frame_Err   = ferr_q;
    assign Dbg_State   = state_q;

endmodule

// File: tb/tb_rx_ctrl_module.sv
// Directed bench for rx_ctrl_module paired with a behavioural RX baud
// generator running at a shortened bit period.
`timescale 1ns/1ps
module tb_rx_ctrl_module;
    import rx_ctrl_module_pkg::*;

    localparam int BIT  = 32;
    localparam int HALF = 16;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       RX_Pin_In = 1'b1;
    logic       RX_En_Sig = 1'b1;
    logic       BPS_CLK;
    logic       Count_Sig;
    logic [7:0] RX_Data;
    logic       RX_Done_Sig;
    logic       Frame_Err;
    rx_state_e  Dbg_State;

    int         checks = 0;
    int         errors = 0;
    int         bcnt;
    int         baud_cnt;
    int         wide_pulse = 0;
    logic       prev_done = 1'b0;
    logic [8:0] got_q[$];

    always #10 CLK = ~CLK;

    rx_ctrl_module #(.DATA_BITS(8)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .RX_Pin_In   (RX_Pin_In),
        .RX_En_Sig   (RX_En_Sig),
        .BPS_CLK     (BPS_CLK),
        .Count_Sig   (Count_Sig),
        .RX_Data     (RX_Data),
        .RX_Done_Sig (RX_Done_Sig),
        .Frame_Err   (Frame_Err),
        .Dbg_State   (Dbg_State)
    );

    // Baud generator model: mid-bit strobe HALF clocks after Count_Sig rises.
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            baud_cnt <= 0;
            BPS_CLK  <= 1'b0;
        end else if (!Count_Sig) begin
            baud_cnt <= 0;
            BPS_CLK  <= 1'b0;
        end else begin
            baud_cnt <= (baud_cnt == BIT - 1) ? 0 : baud_cnt + 1;
            BPS_CLK  <= (baud_cnt == HALF - 1);
        end
    end

    // Capture every done pulse together with its data and error flag.
    always @(negedge CLK) begin
        if (RX_Done_Sig) begin
            got_q.push_back({Frame_Err, RX_Data});
            if (prev_done) wide_pulse <= wide_pulse + 1;
        end
        prev_done <= RX_Done_Sig;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic f);
        logic [8:0] g;
        chk({tag, "_present"}, 32'(got_q.size() > 0), 32'd1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            chk({tag, "_data"}, 32'(g[7:0]), 32'(d));
            chk({tag, "_ferr"}, 32'(g[8]), 32'(f));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Start bit, ndata LSB-first data bits, and a stop bit only for full frames.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ndata);
        RX_Pin_In = 1'b0;
        idle(BIT);
        for (int i = 0; i < ndata; i++) begin
            RX_Pin_In = d[i];
            idle(BIT);
        end
        if (ndata == 8) begin
            RX_Pin_In = stop;
            idle(BIT);
        end
    endtask

    initial begin
        idle(3);
        chk("rst_count", 32'(Count_Sig), 32'd0);
        chk("rst_done",  32'(RX_Done_Sig), 32'd0);
        chk("rst_ferr",  32'(Frame_Err), 32'd0);
        chk("rst_data",  32'(RX_Data), 32'h00);
        chk("rst_state", 32'(Dbg_State), 32'(ST_IDLE));
        RSTn = 1'b1;
        idle(BIT);

        // Clean frame 0x55
        send_frame(8'h55, 1'b1, 8);
        idle(BIT);
        pop_chk("f55", 8'h55, 1'b0);
        chk("f55_extra", 32'(got_q.size()), 32'd0);
        chk("f55_count_low", 32'(Count_Sig), 32'd0);
        chk("f55_ferr_idle", 32'(Frame_Err), 32'd0);
        chk("f55_data_hold", 32'(RX_Data), 32'h55);

        // Short low glitch: start rejected at the first strobe
        RX_Pin_In = 1'b0;
        idle(8);
        RX_Pin_In = 1'b1;
        bcnt = 0;
        while (BPS_CLK !== 1'b1 && bcnt < 4 * BIT) begin
            @(negedge CLK);
            bcnt++;
        end
        chk("glitch_bps_seen", 32'(BPS_CLK), 32'd1);
        chk("glitch_count_before", 32'(Count_Sig), 32'd1);
        @(negedge CLK);
        chk("glitch_count_drop", 32'(Count_Sig), 32'd0);
        idle(2 * BIT);
        chk("glitch_no_done", 32'(got_q.size()), 32'd0);
        chk("glitch_data", 32'(RX_Data), 32'h55);

        // Frame 0xA3 with a low stop bit; line then stays low
        send_frame(8'hA3, 1'b0, 8);
        idle(3 * BIT);
        chk("a3_no_retrigger", 32'(Count_Sig), 32'd0);
        pop_chk("fa3", 8'hA3, 1'b1);
        chk("fa3_extra", 32'(got_q.size()), 32'd0);
        chk("fa3_ferr_cleared", 32'(Frame_Err), 32'd0);
        chk("fa3_data_hold", 32'(RX_Data), 32'hA3);
        RX_Pin_In = 1'b1;
        idle(2 * BIT);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, 8);
        send_frame(8'hFF, 1'b1, 8);
        idle(BIT);
        pop_chk("b2b0", 8'h00, 1'b0);
        pop_chk("b2b1", 8'hFF, 1'b0);
        chk("b2b_extra", 32'(got_q.size()), 32'd0);

        // Reset in the middle of 0x3C, then a fresh frame 0xC3
        send_frame(8'h3C, 1'b1, 4);
        RSTn = 1'b0;
        @(negedge CLK);
        chk("rst2_count", 32'(Count_Sig), 32'd0);
        chk("rst2_data",  32'(RX_Data), 32'h00);
        chk("rst2_done",  32'(RX_Done_Sig), 32'd0);
        chk("rst2_ferr",  32'(Frame_Err), 32'd0);
        chk("rst2_state", 32'(Dbg_State), 32'(ST_IDLE));
        RX_Pin_In = 1'b1;
        idle(BIT);
        RSTn = 1'b1;
        idle(BIT);
        chk("rst2_no_done", 32'(got_q.size()), 32'd0);
        send_frame(8'hC3, 1'b1, 8);
        idle(BIT);
        pop_chk("fc3", 8'hC3, 1'b0);
        chk("fc3_extra", 32'(got_q.size()), 32'd0);

        // Disable during the data bits of 0x81
        send_frame(8'h81, 1'b1, 3);
        chk("abort_count_before", 32'(Count_Sig), 32'd1);
        RX_En_Sig = 1'b0;
        @(negedge CLK);
        chk("abort_count_drop", 32'(Count_Sig), 32'd0);
        chk("abort_state", 32'(Dbg_State), 32'(ST_IDLE));
        RX_Pin_In = 1'b1;
        idle(BIT);
        send_frame(8'h42, 1'b1, 8);
        idle(BIT);
        chk("disabled_no_done", 32'(got_q.size()), 32'd0);
        chk("disabled_data", 32'(RX_Data), 32'hC3);

        // Re-enable and receive normally again
        RX_En_Sig = 1'b1;
        idle(BIT);
        send_frame(8'h5A, 1'b1, 8);
        idle(BIT);
        pop_chk("f5a", 8'h5A, 1'b0);
        chk("f5a_extra", 32'(got_q.size()), 32'd0);
        chk("done_width", 32'(wide_pulse), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
